alu_seq_ctrl: RTL and testbench

- Sequencing controller for the shared 16-bit combinational ALU datapath (add/sub/mul/div selected by a 2-bit function code).
- Accepts 16-bit instruction words over a valid/ready handshake and reads both operands from an internal 16x16 register file.
- Drives the ALU select and operand lines, holds them stable for a per-op settle window, captures the result and writes it back.
- Owns the register file that the top-level CPU previously exposed as a combinational write-back array; adds host load, debug read and a divide-by-zero exception.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_regfile_16x16.sv | 34 +++
 rtl/alu_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and instruction field positions for the ALU sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_e;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;

    localparam int OP_HI = 15;
    localparam int OP_LO = 14;
    localparam int RD_HI = 13;
    localparam int RD_LO = 10;
    localparam int RA_HI = 9;
    localparam int RA_LO = 6;
    localparam int RB_HI = 5;
    localparam int RB_LO = 2;
    localparam int C_BIT = 1;

endpackage

// File: rtl/alu_regfile_16x16.sv
// rtl/alu_regfile_16x16.sv - 16x16 register file, one sync write port, three async read ports
module alu_regfile_16x16
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] ra_addr_i,
    input  logic [REG_AW-1:0] rb_addr_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequences instructions through the shared ALU and owns its register file
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [1:0]  alu_f0,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic        alu_bin,
    input  logic [15:0] alu_result,
    input  logic        alu_flag,
    input  logic        host_we,
    input  logic [3:0]  host_waddr,
    input  logic [15:0] host_wdata,
    output logic        host_wready,
    input  logic [3:0]  dbg_raddr,
    output logic [15:0] dbg_rdata,
    output logic        busy,
    output logic        done,
    output logic        flag_c,
    output logic        exc_div0,
    input  logic        exc_clear
);

    localparam int MAX_LAT = (ALU_LAT > DIV_LAT) ? ALU_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e            state_q, state_d;
    op_e               alu_f0_q, alu_f0_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              nowrite_q, nowrite_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              alu_cin_q, alu_cin_d;
    logic              alu_bin_q, alu_bin_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              flag_cap_q, flag_cap_d;
    logic              flag_c_q, flag_c_d;
    logic              exc_div0_q, exc_div0_d;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] ra_data, rb_data;
    logic              div0_set;

    op_e               op_in;
    logic              unused_rsvd;

    assign op_in       = op_e'(instr[OP_HI:OP_LO]);
    assign unused_rsvd = instr[0];

    alu_regfile_16x16 u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .ra_addr_i  (instr[RA_HI:RA_LO]),
        .rb_addr_i  (instr[RB_HI:RB_LO]),
        .dbg_addr_i (dbg_raddr),
        .ra_data_o  (ra_data),
        .rb_data_o  (rb_data),
        .dbg_data_o (dbg_rdata)
    );

    always_comb begin
        state_d     = state_q;
        alu_f0_d    = alu_f0_q;
        rd_d        = rd_q;
        nowrite_d   = nowrite_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_bin_d   = alu_bin_q;
        result_d    = result_q;
        flag_cap_d  = flag_cap_q;
        flag_c_d    = flag_c_q;
        instr_ready = (state_q == S_IDLE) && !host_we;
        host_wready = (state_q == S_IDLE);
        rf_we       = 1'b0;
        rf_waddr    = host_waddr;
        rf_wdata    = host_wdata;
        done        = 1'b0;
        div0_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Host write wins the single write port and blocks accept this cycle.
                if (host_we) begin
                    rf_we = 1'b1;
                end else if (instr_valid) begin
                    alu_f0_d  = op_in;
                    rd_d      = instr[RD_HI:RD_LO];
                    alu_a_d   = ra_data;
                    alu_b_d   = rb_data;
                    alu_cin_d = (op_in == OP_ADD) && instr[C_BIT];
                    alu_bin_d = (op_in == OP_SUB) && instr[C_BIT];
                    if (op_in == OP_DIV && rb_data == '0) begin
                        nowrite_d = 1'b1;
                        div0_set  = 1'b1;
                        state_d   = S_WB;
                    end else begin
                        nowrite_d = 1'b0;
                        cnt_d     = (op_in == OP_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(ALU_LAT);
                        state_d   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    result_d   = alu_result;
                    flag_cap_d = alu_flag;
                    state_d    = S_WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WB: begin
                done = 1'b1;
                if (!nowrite_q) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = result_q;
                    flag_c_d = (alu_f0_q == OP_ADD || alu_f0_q == OP_SUB) ? flag_cap_q : 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        exc_div0_d = div0_set ? 1'b1 : (exc_clear ? 1'b0 : exc_div0_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            alu_f0_q   <= OP_ADD;
            rd_q       <= '0;
            nowrite_q  <= 1'b0;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_bin_q  <= 1'b0;
            result_q   <= '0;
            flag_cap_q <= 1'b0;
            flag_c_q   <= 1'b0;
            exc_div0_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_f0_q   <= alu_f0_d;
            rd_q       <= rd_d;
            nowrite_q  <= nowrite_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_bin_q  <= alu_bin_d;
            result_q   <= result_d;
            flag_cap_q <= flag_cap_d;
            flag_c_q   <= flag_c_d;
            exc_div0_q <= exc_div0_d;
        end
    end

    assign alu_f0   = alu_f0_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_cin  = alu_cin_q;
    assign alu_bin  = alu_bin_q;
    assign busy     = (state_q != S_IDLE);
    assign flag_c   = flag_c_q;
    assign exc_div0 = exc_div0_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [1:0]  alu_f0;
    logic [15:0] alu_a, alu_b;
    logic        alu_cin, alu_bin;
    logic [15:0] alu_result;
    logic        alu_flag;
    logic        host_we;
    logic [3:0]  host_waddr;
    logic [15:0] host_wdata;
    logic        host_wready;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;
    logic        busy, done, flag_c, exc_div0, exc_clear;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.ALU_LAT(1), .DIV_LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_f0      (alu_f0),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_bin     (alu_bin),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .host_we     (host_we),
        .host_waddr  (host_waddr),
        .host_wdata  (host_wdata),
        .host_wready (host_wready),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata),
        .busy        (busy),
        .done        (done),
        .flag_c      (flag_c),
        .exc_div0    (exc_div0),
        .exc_clear   (exc_clear)
    );

    // Reference ALU: 17-bit sums give carry-out, borrow is a < b + bin.
    always_comb begin
        logic [16:0] wide;
        wide       = '0;
        alu_flag   = 1'b0;
        alu_result = '0;
        case (alu_f0)
            2'b00: begin
                wide       = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
                alu_result = wide[15:0];
                alu_flag   = wide[16];
            end
            2'b01: begin
                wide       = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_bin};
                alu_result = wide[15:0];
                alu_flag   = wide[16];
            end
            2'b10: alu_result = alu_a * alu_b;
            default: alu_result = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] mk(input logic [1:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb, input logic c);
        return {op, rd, ra, rb, c, 1'b0};
    endfunction

    task automatic reg_chk(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        dbg_raddr = addr;
        #1;
        check(tag, {16'd0, dbg_rdata}, {16'd0, exp});
    endtask

    task automatic host_write(input logic [3:0] addr, input logic [15:0] data);
        int k;
        host_we    = 1'b1;
        host_waddr = addr;
        host_wdata = data;
        k = 0;
        while (!host_wready && k < 20) begin
            tick();
            k++;
        end
        check("host_wready", {31'd0, host_wready}, 32'd1);
        tick();
        host_we = 1'b0;
    endtask

    // Issues one instruction, then checks done latency and the instr_ready-low window.
    task automatic run_instr(input logic [15:0] w, input int lat, input string tag);
        int k;
        int low;
        instr       = w;
        instr_valid = 1'b1;
        k = 0;
        while (!instr_ready && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        low = 0;
        for (k = 1; k < 40; k++) begin
            if (!instr_ready) low++;
            if (done) break;
            tick();
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_rdylow"}, low, lat);
        tick();
        check({tag, "_idle"}, {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        int done_seen;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        host_we     = 1'b0;
        host_waddr  = '0;
        host_wdata  = '0;
        dbg_raddr   = '0;
        exc_clear   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_done",  {31'd0, done},     32'd0);
        check("rst_flagc", {31'd0, flag_c},   32'd0);
        check("rst_exc",   {31'd0, exc_div0}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a},    32'd0);
        check("rst_f0",    {30'd0, alu_f0},   32'd0);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        reg_chk("rst_r5", 4'd5, 16'h0000);

        host_write(4'd1, 16'h0003);
        host_write(4'd2, 16'h0005);
        reg_chk("host_r1", 4'd1, 16'h0003);
        reg_chk("host_r2", 4'd2, 16'h0005);

        run_instr(mk(2'b00, 4'd3, 4'd1, 4'd2, 1'b1), 2, "add");
        reg_chk("add_r3", 4'd3, 16'h0009);
        check("add_flagc", {31'd0, flag_c}, 32'd0);

        run_instr(mk(2'b01, 4'd4, 4'd1, 4'd2, 1'b0), 2, "sub");
        reg_chk("sub_r4", 4'd4, 16'hFFFE);
        check("sub_flagc", {31'd0, flag_c}, 32'd1);

        run_instr(mk(2'b10, 4'd5, 4'd2, 4'd2, 1'b1), 2, "mul");
        reg_chk("mul_r5", 4'd5, 16'h0019);
        check("mul_flagc", {31'd0, flag_c}, 32'd0);
        check("mul_nocin", {31'd0, alu_cin}, 32'd0);

        run_instr(mk(2'b11, 4'd6, 4'd2, 4'd1, 1'b0), 5, "div");
        reg_chk("div_r6", 4'd6, 16'h0001);
        check("div_hold_f0", {30'd0, alu_f0}, 32'd3);
        check("div_hold_b",  {16'd0, alu_b},  32'd3);

        run_instr(mk(2'b01, 4'd8, 4'd1, 4'd2, 1'b0), 2, "sub2");
        check("sub2_flagc", {31'd0, flag_c}, 32'd1);

        run_instr(mk(2'b11, 4'd6, 4'd2, 4'd0, 1'b0), 1, "div0");
        reg_chk("div0_r6", 4'd6, 16'h0001);
        check("div0_exc",   {31'd0, exc_div0}, 32'd1);
        check("div0_flagc", {31'd0, flag_c},   32'd1);

        instr       = mk(2'b11, 4'd7, 4'd1, 4'd0, 1'b0);
        instr_valid = 1'b1;
        exc_clear   = 1'b1;
        tick();
        instr_valid = 1'b0;
        exc_clear   = 1'b0;
        check("div0b_done", {31'd0, done},     32'd1);
        check("div0b_exc",  {31'd0, exc_div0}, 32'd1);
        tick();
        reg_chk("div0b_r7", 4'd7, 16'h0000);
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        check("exc_cleared", {31'd0, exc_div0}, 32'd0);

        host_we     = 1'b1;
        host_waddr  = 4'd1;
        host_wdata  = 16'h0010;
        instr       = mk(2'b00, 4'd9, 4'd1, 4'd2, 1'b0);
        instr_valid = 1'b1;
        #1;
        check("arb_ready",  {31'd0, instr_ready}, 32'd0);
        check("arb_wready", {31'd0, host_wready}, 32'd1);
        tick();
        host_we = 1'b0;
        run_instr(mk(2'b00, 4'd9, 4'd1, 4'd2, 1'b0), 2, "arb");
        reg_chk("arb_r9", 4'd9, 16'h0015);

        run_instr(mk(2'b00, 4'd1, 4'd1, 4'd1, 1'b0), 2, "alias");
        reg_chk("alias_r1", 4'd1, 16'h0020);

        instr       = mk(2'b00, 4'd7, 4'd1, 4'd2, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst2_busy", {31'd0, busy},     32'd0);
        check("rst2_done", {31'd0, done},     32'd0);
        check("rst2_exc",  {31'd0, exc_div0}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            reg_chk($sformatf("rst2_r%0d", i), 4'(i), 16'h0000);
        end
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("rst2_nodone", done_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
